// File: rtl/venda_pkg.sv
// Shared types and constants for the vending-machine sale sequencer.
// Optional stock tracking is built only when ESTOQUE_EN is defined.
package venda_pkg;

  localparam int PROD_W    = 4;
  localparam int PRECO_W   = 3;
  localparam int MOEDA_W   = 2;
  localparam int N_PROD    = 1 << PROD_W;
  localparam int ESTOQUE_W = 4;
  localparam logic [ESTOQUE_W-1:0] ESTOQUE_INI = 4'd9;

  // Encoding is visible on the estados output, so values are fixed.
  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    SELECIONADO = 3'd1,
    PAGANDO     = 3'd2,
    LIBERANDO   = 3'd3,
    TROCO       = 3'd4
  } estado_t;

  // States in which inserted coins are credited rather than rejected.
  function automatic logic aceita_moedas(input estado_t e);
    return (e == OCIOSO) || (e == SELECIONADO) || (e == PAGANDO);
  endfunction

  // States in which the buyer may still cancel and the timeout runs.
  function automatic logic em_selecao(input estado_t e);
    return (e == SELECIONADO) || (e == PAGANDO);
  endfunction

endpackage

// File: rtl/controle_venda_if.sv
// Bundle of keypad, coin, dispenser and change-hopper signals of the sale sequencer.
// The esgotado line exists only when ESTOQUE_EN is defined.
interface controle_venda_if #(
  parameter int CRED_W = 4
);
  import venda_pkg::*;

  // Every *_ack/OK/cancela/moeda_ok input is a single-cycle pulse; dispensar
  // and troco_req are levels held until the matching ack is sampled high.
  logic                existe;
  logic [PROD_W-1:0]   produto;
  logic [PRECO_W-1:0]  valor;
  logic                OK;
  logic                cancela;
  logic                moeda_ok;
  logic [MOEDA_W-1:0]  moeda_val;
  logic                disp_ack;
  logic                troco_ack;
  logic                dispensar;
  logic [PROD_W-1:0]   produto_out;
  logic                troco_req;
  logic [CRED_W-1:0]   credito;
  logic                moeda_rejeita;
  logic                limpa_digitos;
  logic [2:0]          estados;
`ifdef ESTOQUE_EN
  logic                esgotado;
`endif

  modport slave (
    input  existe, produto, valor, OK, cancela, moeda_ok, moeda_val,
           disp_ack, troco_ack,
    output dispensar, produto_out, troco_req, credito, moeda_rejeita,
           limpa_digitos, estados
`ifdef ESTOQUE_EN
    , output esgotado
`endif
  );

  modport master (
    output existe, produto, valor, OK, cancela, moeda_ok, moeda_val,
           disp_ack, troco_ack,
    input  dispensar, produto_out, troco_req, credito, moeda_rejeita,
           limpa_digitos, estados
`ifdef ESTOQUE_EN
    , input esgotado
`endif
  );

endinterface

// File: rtl/controle_venda_temporizador.sv
// Idle timeout for the selection/payment phase: counts while run is high,
// restarts on clear, and flags expira once TIMEOUT_CICLOS-1 is reached.
module temporizador_venda #(
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expira
);

  localparam int CNT_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [CNT_W-1:0] LIMITE = CNT_W'(TIMEOUT_CICLOS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter saturates at LIMITE so expira stays asserted until cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && (cnt_q != LIMITE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expira = run && (cnt_q == LIMITE);

endmodule

// File: rtl/controle_venda.sv
// Sale sequencer: selection, coin credit, dispense and unit-by-unit change.
// Defining ESTOQUE_EN adds per-product stock counters and the esgotado output.
module controle_venda
  import venda_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 1000,
  parameter int CRED_W         = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  controle_venda_if.slave     bus
);

  localparam logic [CRED_W-1:0] CRED_MAX = '1;

  estado_t             estado_q, estado_d;
  logic [CRED_W-1:0]   credito_q, credito_d;
  logic [PROD_W-1:0]   produto_q, produto_d;
  logic [PRECO_W-1:0]  preco_q, preco_d;
  logic                rejeita_q, rejeita_d;
  logic                limpa_q, limpa_d;

  logic [CRED_W:0]     moeda_ext;
  logic [CRED_W:0]     soma;
  logic [CRED_W-1:0]   credito_pos;
  logic [CRED_W-1:0]   preco_ext;
  logic [CRED_W-1:0]   resto;
  logic                moeda_valida, moeda_cabe, moeda_aceita;
  logic                vendavel, entrega, expira;
  logic                tmr_run, tmr_clear;

  // Coin path: the extra sum bit exposes overflow past CRED_MAX.
  assign moeda_ext    = {{(CRED_W + 1 - MOEDA_W){1'b0}}, bus.moeda_val};
  assign soma         = {1'b0, credito_q} + moeda_ext;
  assign moeda_valida = bus.moeda_ok && (bus.moeda_val != '0);
  assign moeda_cabe   = (soma <= {1'b0, CRED_MAX});
  assign moeda_aceita = moeda_valida && aceita_moedas(estado_q) && moeda_cabe;
  assign credito_pos  = moeda_aceita ? soma[CRED_W-1:0] : credito_q;
  assign rejeita_d    = moeda_valida && !moeda_aceita;

  assign preco_ext = {{(CRED_W - PRECO_W){1'b0}}, preco_q};
  assign resto     = credito_q - preco_ext;
  assign entrega   = (estado_q == LIBERANDO) && bus.disp_ack;

`ifdef ESTOQUE_EN
  logic [ESTOQUE_W-1:0] estoque_q [N_PROD];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PROD; i++) begin
        estoque_q[i] <= ESTOQUE_INI;
      end
    end else if (entrega && (estoque_q[produto_q] != '0)) begin
      estoque_q[produto_q] <= estoque_q[produto_q] - ESTOQUE_W'(1);
    end
  end

  assign vendavel     = bus.existe && (estoque_q[bus.produto] != '0);
  assign bus.esgotado = (estado_q == OCIOSO) ? (estoque_q[bus.produto] == '0)
                                             : (estoque_q[produto_q] == '0);
`else
  assign vendavel = bus.existe;
`endif

  always_comb begin
    estado_d  = estado_q;
    credito_d = credito_pos;
    produto_d = produto_q;
    preco_d   = preco_q;
    limpa_d   = 1'b0;
    unique case (estado_q)
      OCIOSO: begin
        if (bus.OK) begin
          if (vendavel) begin
            produto_d = bus.produto;
            preco_d   = bus.valor;
            estado_d  = SELECIONADO;
          end else begin
            limpa_d = 1'b1;
          end
        end
      end
      SELECIONADO, PAGANDO: begin
        // A coin accepted this cycle restarts the timeout, so it masks expira.
        if (bus.cancela || (expira && !moeda_aceita)) begin
          estado_d = (credito_pos != '0) ? TROCO : OCIOSO;
          limpa_d  = 1'b1;
        end else if (credito_q >= preco_ext) begin
          estado_d = LIBERANDO;
        end else begin
          estado_d = PAGANDO;
        end
      end
      LIBERANDO: begin
        if (bus.disp_ack) begin
          credito_d = resto;
          estado_d  = (resto != '0) ? TROCO : OCIOSO;
          limpa_d   = 1'b1;
        end
      end
      TROCO: begin
        if (credito_q == '0) begin
          estado_d = OCIOSO;
        end else if (bus.troco_ack) begin
          credito_d = credito_q - CRED_W'(1);
          if (credito_q == CRED_W'(1)) begin
            estado_d = OCIOSO;
          end
        end
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= OCIOSO;
      credito_q <= '0;
      produto_q <= '0;
      preco_q   <= '0;
      rejeita_q <= 1'b0;
      limpa_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      credito_q <= credito_d;
      produto_q <= produto_d;
      preco_q   <= preco_d;
      rejeita_q <= rejeita_d;
      limpa_q   <= limpa_d;
    end
  end

  assign tmr_run   = em_selecao(estado_q);
  assign tmr_clear = (estado_d != estado_q) || moeda_aceita;

  temporizador_venda #(
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
  ) u_temporizador (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (tmr_run),
    .clear  (tmr_clear),
    .expira (expira)
  );

  assign bus.dispensar     = (estado_q == LIBERANDO);
  assign bus.troco_req     = (estado_q == TROCO);
  assign bus.produto_out   = produto_q;
  assign bus.credito       = credito_q;
  assign bus.moeda_rejeita = rejeita_q;
  assign bus.limpa_digitos = limpa_q;
  assign bus.estados       = estado_q;

endmodule

// File: tb/tb_controle_venda.sv
// Bench for controle_venda: directed scenarios plus randomized purchases
// checked against an arithmetic credit/change model.
module tb_controle_venda;
  import venda_pkg::*;

  localparam int T_OUT    = 20;
  localparam int CRED_W   = 4;
  localparam int CRED_MAX = 15;
  localparam logic [2:0] E_OCIOSO = 3'd0;
  localparam logic [2:0] E_SEL    = 3'd1;
  localparam logic [2:0] E_PAG    = 3'd2;
  localparam logic [2:0] E_LIB    = 3'd3;
  localparam logic [2:0] E_TROCO  = 3'd4;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cred_m;
  logic [PROD_W-1:0] exp_q[$];

  controle_venda_if #(.CRED_W(CRED_W)) bus ();

  controle_venda #(.TIMEOUT_CICLOS(T_OUT), .CRED_W(CRED_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  task automatic zera_entradas();
    bus.existe = 1'b0; bus.produto = '0; bus.valor = '0; bus.OK = 1'b0;
    bus.cancela = 1'b0; bus.moeda_ok = 1'b0; bus.moeda_val = '0;
    bus.disp_ack = 1'b0; bus.troco_ack = 1'b0;
  endtask

  task automatic do_reset();
    zera_entradas();
    rst_n = 1'b0;
    ciclo();
    ciclo();
    rst_n = 1'b1;
    ciclo();
  endtask

  // ---------------- drivers ----------------
  task automatic moeda(input int v);
    bus.moeda_ok = 1'b1; bus.moeda_val = MOEDA_W'(v);
    ciclo();
    bus.moeda_ok = 1'b0; bus.moeda_val = '0;
  endtask

  task automatic seleciona(input int p, input int preco, input bit ex);
    bus.produto = PROD_W'(p); bus.valor = PRECO_W'(preco); bus.existe = ex;
    bus.OK = 1'b1;
    ciclo();
    bus.OK = 1'b0;
  endtask

  task automatic cancela();
    bus.cancela = 1'b1; ciclo(); bus.cancela = 1'b0;
  endtask

  task automatic ack_dispensa();
    bus.disp_ack = 1'b1; ciclo(); bus.disp_ack = 1'b0;
  endtask

  task automatic recolhe_troco(output int n);
    int guard;
    n = 0;
    guard = 0;
    while (bus.troco_req === 1'b1 && guard < 40) begin
      repeat ($urandom_range(0, 1)) ciclo();
      bus.troco_ack = 1'b1; ciclo(); bus.troco_ack = 1'b0;
      n++;
      guard++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    zera_entradas();
    rst_n = 1'b0;
    ciclo();
    n_checks++; if (bus.estados !== E_OCIOSO) begin n_fail++; $display("FAIL reset_estado: got %0d want %0d", bus.estados, E_OCIOSO); end
    n_checks++; if (bus.credito !== 4'd0) begin n_fail++; $display("FAIL reset_credito: got %0d want 0", bus.credito); end
    n_checks++; if (bus.produto_out !== 4'd0) begin n_fail++; $display("FAIL reset_produto: got %0d want 0", bus.produto_out); end
    n_checks++; if ({bus.dispensar, bus.troco_req, bus.moeda_rejeita, bus.limpa_digitos} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_saidas: got %b want 0000", {bus.dispensar, bus.troco_req, bus.moeda_rejeita, bus.limpa_digitos}); end
    rst_n = 1'b1;
    ciclo();
  endtask

  task automatic test_precredito();
    int n;
    do_reset();
    moeda(2); moeda(2);
    n_checks++; if (bus.credito !== 4'd4) begin n_fail++; $display("FAIL pre_credito: got %0d want 4", bus.credito); end
    seleciona(5, 3, 1'b1);
    n_checks++; if (bus.estados !== E_SEL || bus.dispensar !== 1'b0) begin n_fail++; $display("FAIL pre_ok1: estado %0d disp %b want 1/0", bus.estados, bus.dispensar); end
    ciclo();
    n_checks++; if (bus.dispensar !== 1'b1 || bus.produto_out !== 4'd5) begin n_fail++; $display("FAIL pre_disp: disp %b prod %0d want 1/5", bus.dispensar, bus.produto_out); end
    ack_dispensa();
    n_checks++; if (bus.estados !== E_TROCO || bus.credito !== 4'd1 || bus.limpa_digitos !== 1'b1) begin
      n_fail++; $display("FAIL pre_apos_ack: estado %0d cred %0d limpa %b want 4/1/1", bus.estados, bus.credito, bus.limpa_digitos); end
    recolhe_troco(n);
    n_checks++; if (n != 1) begin n_fail++; $display("FAIL pre_troco: got %0d units want 1", n); end
    n_checks++; if (bus.estados !== E_OCIOSO || bus.credito !== 4'd0 || bus.troco_req !== 1'b0) begin
      n_fail++; $display("FAIL pre_fim: estado %0d cred %0d req %b want 0/0/0", bus.estados, bus.credito, bus.troco_req); end
  endtask

  task automatic test_paga_depois();
    int seq[4] = '{2, 2, 2, 1};
    do_reset();
    seleciona(2, 7, 1'b1);
    ciclo();
    foreach (seq[i]) begin
      moeda(seq[i]);
      n_checks++; if (bus.estados !== E_PAG) begin n_fail++; $display("FAIL pag_estado_%0d: got %0d want %0d", i, bus.estados, E_PAG); end
    end
    n_checks++; if (bus.credito !== 4'd7) begin n_fail++; $display("FAIL pag_credito: got %0d want 7", bus.credito); end
    ciclo();
    n_checks++; if (bus.estados !== E_LIB) begin n_fail++; $display("FAIL pag_liberando: got %0d want %0d", bus.estados, E_LIB); end
    ack_dispensa();
    n_checks++; if (bus.credito !== 4'd0 || bus.troco_req !== 1'b0 || bus.estados !== E_OCIOSO) begin
      n_fail++; $display("FAIL pag_fim: cred %0d req %b estado %0d want 0/0/0", bus.credito, bus.troco_req, bus.estados); end
  endtask

  task automatic test_cancela();
    int n;
    do_reset();
    seleciona(1, 6, 1'b1);
    ciclo();
    moeda(2); moeda(2);
    cancela();
    n_checks++; if (bus.limpa_digitos !== 1'b1 || bus.estados !== E_TROCO) begin
      n_fail++; $display("FAIL canc_saida: limpa %b estado %0d want 1/4", bus.limpa_digitos, bus.estados); end
    moeda(1);
    n_checks++; if (bus.moeda_rejeita !== 1'b1 || bus.credito !== 4'd4) begin
      n_fail++; $display("FAIL canc_moeda_troco: rej %b cred %0d want 1/4", bus.moeda_rejeita, bus.credito); end
    recolhe_troco(n);
    n_checks++; if (n != 4 || bus.estados !== E_OCIOSO) begin n_fail++; $display("FAIL canc_troco: units %0d estado %0d want 4/0", n, bus.estados); end
  endtask

  task automatic test_simultaneo();
    int n;
    do_reset();
    // Coin in the same cycle as OK: credited and the selection still latches.
    bus.moeda_ok = 1'b1; bus.moeda_val = 2'd2;
    seleciona(9, 2, 1'b1);
    bus.moeda_ok = 1'b0; bus.moeda_val = '0;
    n_checks++; if (bus.estados !== E_SEL || bus.credito !== 4'd2) begin n_fail++; $display("FAIL simul_ok: estado %0d cred %0d want 1/2", bus.estados, bus.credito); end
    ciclo();
    n_checks++; if (bus.dispensar !== 1'b1 || bus.produto_out !== 4'd9) begin n_fail++; $display("FAIL simul_disp: disp %b prod %0d want 1/9", bus.dispensar, bus.produto_out); end
    ack_dispensa();
    // Cancel with a coin in PAGANDO: coin credited, then all refunded.
    seleciona(3, 7, 1'b1);
    ciclo();
    moeda(3);
    bus.moeda_ok = 1'b1; bus.moeda_val = 2'd2;
    cancela();
    bus.moeda_ok = 1'b0; bus.moeda_val = '0;
    n_checks++; if (bus.estados !== E_TROCO || bus.credito !== 4'd5) begin n_fail++; $display("FAIL simul_canc: estado %0d cred %0d want 4/5", bus.estados, bus.credito); end
    recolhe_troco(n);
    n_checks++; if (n != 5) begin n_fail++; $display("FAIL simul_troco: units %0d want 5", n); end
  endtask

  task automatic test_overflow();
    int seq[5] = '{3, 3, 3, 3, 2};
    do_reset();
    foreach (seq[i]) moeda(seq[i]);
    n_checks++; if (bus.credito !== 4'd14) begin n_fail++; $display("FAIL ovf_base: got %0d want 14", bus.credito); end
    moeda(3);
    n_checks++; if (bus.moeda_rejeita !== 1'b1 || bus.credito !== 4'd14) begin n_fail++; $display("FAIL ovf_rejeita: rej %b cred %0d want 1/14", bus.moeda_rejeita, bus.credito); end
    ciclo();
    n_checks++; if (bus.moeda_rejeita !== 1'b0) begin n_fail++; $display("FAIL ovf_pulso: rej %b want 0", bus.moeda_rejeita); end
    moeda(1);
    n_checks++; if (bus.moeda_rejeita !== 1'b0 || bus.credito !== 4'd15) begin n_fail++; $display("FAIL ovf_max: rej %b cred %0d want 0/15", bus.moeda_rejeita, bus.credito); end
  endtask

  task automatic test_timeout();
    int k, n;
    // SELECIONADO costs one cycle, then PAGANDO waits the full T_OUT.
    do_reset();
    moeda(1);
    seleciona(4, 5, 1'b1);
    for (k = 1; k <= 60; k++) begin ciclo(); if (bus.estados === E_TROCO) break; end
    n_checks++; if (k != T_OUT + 1) begin n_fail++; $display("FAIL tout_ciclos: got %0d want %0d", k, T_OUT + 1); end
    recolhe_troco(n);
    n_checks++; if (n != 1) begin n_fail++; $display("FAIL tout_troco: units %0d want 1", n); end
    // A coin restarts the count from the coin cycle.
    do_reset();
    moeda(1);
    seleciona(4, 5, 1'b1);
    repeat (10) ciclo();
    moeda(1);
    for (k = 1; k <= 60; k++) begin ciclo(); if (bus.estados === E_TROCO) break; end
    n_checks++; if (k != T_OUT) begin n_fail++; $display("FAIL tout_reinicio: got %0d want %0d", k, T_OUT); end
    recolhe_troco(n);
    n_checks++; if (n != 2) begin n_fail++; $display("FAIL tout_troco2: units %0d want 2", n); end
  endtask

  task automatic test_invalido_reset();
    do_reset();
    seleciona(3, 4, 1'b0);
    n_checks++; if (bus.limpa_digitos !== 1'b1 || bus.estados !== E_OCIOSO) begin
      n_fail++; $display("FAIL inval: limpa %b estado %0d want 1/0", bus.limpa_digitos, bus.estados); end
    moeda(2);
    seleciona(6, 1, 1'b1);
    ciclo();
    n_checks++; if (bus.dispensar !== 1'b1) begin n_fail++; $display("FAIL rst_meio_pre: disp %b want 1", bus.dispensar); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.dispensar !== 1'b0 || bus.credito !== 4'd0 || bus.estados !== E_OCIOSO) begin
      n_fail++; $display("FAIL rst_meio: disp %b cred %0d estado %0d want 0/0/0", bus.dispensar, bus.credito, bus.estados); end
    ciclo();
    rst_n = 1'b1;
    ciclo();
  endtask

  task automatic test_preco_zero();
    int n;
    do_reset();
    moeda(3);
    seleciona(12, 0, 1'b1);
    ciclo();
    n_checks++; if (bus.dispensar !== 1'b1) begin n_fail++; $display("FAIL zero_disp: disp %b want 1", bus.dispensar); end
    ack_dispensa();
    recolhe_troco(n);
    n_checks++; if (n != 3) begin n_fail++; $display("FAIL zero_troco: units %0d want 3", n); end
  endtask

  task automatic test_aleatorio();
    int prod, preco, v, n, n_pre, troco_esp;
    bit rej_esp;
    logic [PROD_W-1:0] p_esp;
    do_reset();
    cred_m = 0;
    for (int it = 0; it < 30; it++) begin
      prod  = $urandom_range(0, 15);
      preco = $urandom_range(0, 7);
      n_pre = $urandom_range(0, 6);
      for (int j = 0; j < n_pre; j++) begin
        v = $urandom_range(0, 3);
        rej_esp = (v != 0) && (cred_m + v > CRED_MAX);
        if (v != 0 && !rej_esp) cred_m += v;
        moeda(v);
        n_checks++; if (bus.credito !== CRED_W'(cred_m) || bus.moeda_rejeita !== rej_esp) begin
          n_fail++; $display("FAIL rnd_pre_%0d: cred %0d rej %b want %0d/%b", it, bus.credito, bus.moeda_rejeita, cred_m, rej_esp); end
      end
      seleciona(prod, preco, 1'b1);
      exp_q.push_back(PROD_W'(prod));
      ciclo();
      if (cred_m < preco && $urandom_range(0, 3) == 0) begin
        cancela();
        void'(exp_q.pop_front());
        recolhe_troco(n);
        n_checks++; if (n != cred_m || bus.estados !== E_OCIOSO) begin
          n_fail++; $display("FAIL rnd_canc_%0d: units %0d estado %0d want %0d/0", it, n, bus.estados, cred_m); end
        cred_m = 0;
        continue;
      end
      while (cred_m < preco) begin
        v = $urandom_range(1, 3);
        cred_m += v;
        moeda(v);
      end
      if (bus.estados !== E_LIB) ciclo();
      p_esp = exp_q.pop_front();
      n_checks++; if (bus.dispensar !== 1'b1 || bus.produto_out !== p_esp || bus.credito !== CRED_W'(cred_m)) begin
        n_fail++; $display("FAIL rnd_disp_%0d: disp %b prod %0d cred %0d want 1/%0d/%0d", it, bus.dispensar, bus.produto_out, bus.credito, p_esp, cred_m); end
      if ($urandom_range(0, 1) == 1) begin
        moeda($urandom_range(1, 3));
        n_checks++; if (bus.moeda_rejeita !== 1'b1 || bus.credito !== CRED_W'(cred_m)) begin
          n_fail++; $display("FAIL rnd_rej_lib_%0d: rej %b cred %0d want 1/%0d", it, bus.moeda_rejeita, bus.credito, cred_m); end
      end
      ack_dispensa();
      troco_esp = cred_m - preco;
      recolhe_troco(n);
      n_checks++; if (n != troco_esp || bus.credito !== 4'd0 || bus.estados !== E_OCIOSO) begin
        n_fail++; $display("FAIL rnd_troco_%0d: units %0d cred %0d estado %0d want %0d/0/0", it, n, bus.credito, bus.estados, troco_esp); end
      cred_m = 0;
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_fila: %0d left want 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    zera_entradas();
    rst_n = 1'b0;
    test_reset();
    test_precredito();
    test_paga_depois();
    test_cancela();
    test_simultaneo();
    test_overflow();
    test_timeout();
    test_invalido_reset();
    test_preco_zero();
    test_aleatorio();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
